// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the fifo_sync_flags codebase slice.
//   cnt_w(depth)      width of an occupancy counter able to hold 0..depth
//   FIFO_DW           default data width
//   FIFO_DEPTH        default storage depth
//   `FIFO_CHECK_DEPTH / `FIFO_CHECK_LEVELS
//                     elaboration-time parameter legality checks, expanded
//                     inside a module body as generate-if blocks
package fifo_pkg;

  localparam int unsigned FIFO_DW    = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`ifndef FIFO_PKG_CHECKS_SVH
`define FIFO_PKG_CHECKS_SVH

`define FIFO_CHECK_DEPTH(D) \
  if ((D) < 2) begin : g_chk_depth \
    $error("fifo: Depth must be >= 2"); \
  end

`define FIFO_CHECK_LEVELS(D, AFL, AEL) \
  if (((AFL) < 1) || ((AFL) > (D))) begin : g_chk_af \
    $error("fifo: AF_Level must be in 1..Depth"); \
  end \
  if (((AEL) < 0) || ((AEL) > ((D) - 1))) begin : g_chk_ae \
    $error("fifo: AE_Level must be in 0..Depth-1"); \
  end

`endif

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: circular pointer for a FIFO of arbitrary depth.
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, pointer -> 0
//   inc    in   advance pointer by one this cycle
//   ptr    out  current pointer, 0..Depth-1
// The pointer wraps from Depth-1 to 0 explicitly, so Depth need not be a
// power of two.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int Depth = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  output logic [$clog2(Depth)-1:0] ptr
);

  localparam int PW = $clog2(Depth);

  `FIFO_CHECK_DEPTH(Depth)

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == PW'(Depth - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk             in   rising-edge clock
//   reset           in   synchronous active-high reset
//   w / r           in   write / read request
//   data_in         in   write data (Data_Width)
//   data_out        out  read data (Data_Width)
//   full_o/empty_o  out  count == Depth / count == 0
//   almost_full_o   out  count >= AF_Level
//   almost_empty_o  out  count <= AE_Level
//   count_o         out  occupancy, cnt_w(Depth) bits
//   overflow_o      out  sticky: a write was rejected
//   underflow_o     out  sticky: a read was rejected
// Build option: FIFO_FWFT_EN selects first-word-fall-through output;
// default is a registered read with one cycle latency.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int Data_Width = FIFO_DW,
  parameter int Depth      = FIFO_DEPTH,
  parameter int AF_Level   = Depth - 1,
  parameter int AE_Level   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w,
  input  logic                      r,
  input  logic [Data_Width-1:0]     data_in,
  output logic [Data_Width-1:0]     data_out,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic [cnt_w(Depth)-1:0]   count_o,
  output logic                      overflow_o,
  output logic                      underflow_o
);

  localparam int CW = cnt_w(Depth);
  localparam int PW = $clog2(Depth);

  `FIFO_CHECK_DEPTH(Depth)
  `FIFO_CHECK_LEVELS(Depth, AF_Level, AE_Level)

  logic [Data_Width-1:0] mem_q [Depth];
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [PW-1:0]         wptr, rptr;
  logic                  rd_acc, wr_acc;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(Depth));

  // A read while full frees a slot in the same edge, so the write rides along.
  assign rd_acc = r && !empty_o;
  assign wr_acc = w && (!full_o || rd_acc);

  fifo_wrap_ptr #(.Depth(Depth)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wptr)
  );

  fifo_wrap_ptr #(.Depth(Depth)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (w && !wr_acc);
    unf_d = unf_q | (r && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wptr] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so the output
  // is deterministic after reset.
  assign data_out = empty_o ? '0 : mem_q[rptr];
`else
  logic [Data_Width-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (rd_acc) begin
      dout_d = mem_q[rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
`endif

  assign almost_full_o  = (count_q >= CW'(AF_Level));
  assign almost_empty_o = (count_q <= CW'(AE_Level));
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: self-checking bench for fifo_sync_flags with
// Data_Width=16, Depth=3, AF_Level=2, AE_Level=1. A queue-based reference
// model tracks contents, sticky flags and the expected read data.
module tb_fifo_sync_flags;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 3;
  localparam int AFL   = 2;
  localparam int AEL   = 1;
  localparam int CW    = cnt_w(DEPTH);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          w = 1'b0;
  logic          r = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o, underflow_o;

  fifo_sync_flags #(
    .Data_Width (DW),
    .Depth      (DEPTH),
    .AF_Level   (AFL),
    .AE_Level   (AEL)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .w              (w),
    .r              (r),
    .data_in        (data_in),
    .data_out       (data_out),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [DW-1:0] m_dout = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",        32'(count_o),        32'(sz));
    chk("empty",        32'(empty_o),        32'(sz == 0));
    chk("full",         32'(full_o),         32'(sz == DEPTH));
    chk("almost_full",  32'(almost_full_o),  32'(sz >= AFL));
    chk("almost_empty", 32'(almost_empty_o), 32'(sz <= AEL));
    chk("overflow",     32'(overflow_o),     32'(m_ovf));
    chk("underflow",    32'(underflow_o),    32'(m_unf));
`ifdef FIFO_FWFT_EN
    if (sz != 0) chk("data_out", 32'(data_out), 32'(q[0]));
`else
    chk("data_out", 32'(data_out), 32'(m_dout));
`endif
  endtask

  // One clock with the given request pattern; the model decides acceptance
  // from its own occupancy, never from the DUT.
  task automatic step(input logic wi, input logic ri, input logic [DW-1:0] di);
    bit rd, wr;
    w = wi;
    r = ri;
    data_in = di;
    rd = ri && (q.size() != 0);
    wr = wi && ((q.size() < DEPTH) || rd);
    @(posedge clk);
    if (rd) m_dout = q.pop_front();
    if (wr) q.push_back(di);
    if (wi && !wr) m_ovf = 1'b1;
    if (ri && !rd) m_unf = 1'b1;
    #1;
    check_all();
  endtask

  // Reset with w and r held high to show they are ignored.
  task automatic do_reset();
    reset = 1'b1;
    w = 1'b1;
    r = 1'b1;
    data_in = DW'($urandom);
    @(posedge clk);
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_dout = '0;
    #1;
    reset = 1'b0;
    w = 1'b0;
    r = 1'b0;
    check_all();
    chk("rst_data_out", 32'(data_out), 32'h0);
  endtask

  initial begin
    // Reset state
    do_reset();

    // Two writes, two reads
    step(1'b1, 1'b0, 16'hABAB);
    chk("seq_count1", 32'(count_o), 32'd1);
`ifdef FIFO_FWFT_EN
    chk("fwft_first", 32'(data_out), 32'hABAB);
`endif
    step(1'b1, 1'b0, 16'h32EF);
    step(1'b0, 1'b1, '0);
`ifndef FIFO_FWFT_EN
    chk("rd_ABAB", 32'(data_out), 32'hABAB);
`endif
    step(1'b0, 1'b1, '0);
`ifndef FIFO_FWFT_EN
    chk("rd_32EF", 32'(data_out), 32'h32EF);
`endif
    chk("seq_empty", 32'(empty_o), 32'd1);

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom));
    chk("fill_full", 32'(full_o), 32'd1);
    step(1'b1, 1'b0, 16'hDDDD);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);

    // Simultaneous read/write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, 16'h1111);
    chk("full_rw_count", 32'(count_o), 32'd3);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
`ifndef FIFO_FWFT_EN
    chk("last_1111", 32'(data_out), 32'h1111);
`endif

    // Underflow, then r&w while empty
    step(1'b0, 1'b1, '0);
    chk("unf_set", 32'(underflow_o), 32'd1);
    step(1'b1, 1'b1, 16'h5A5A);
    chk("empty_rw_count", 32'(count_o), 32'd1);
    step(1'b0, 1'b1, '0);

    // Ten words streamed through, wrapping repeatedly
    do_reset();
    step(1'b1, 1'b0, 16'h1000);
    for (int i = 1; i < 10; i++) step(1'b1, 1'b1, DW'(16'h1000 + i));
    step(1'b0, 1'b1, '0);

    // Reset with two words stored
    step(1'b1, 1'b0, 16'hC0DE);
    step(1'b1, 1'b0, 16'hBEEF);
    do_reset();
    chk("rst2_count", 32'(count_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic wi, ri;
      if (i < 200) begin
        wi = ($urandom_range(0, 99) < 65);
        ri = ($urandom_range(0, 99) < 40);
      end else begin
        wi = ($urandom_range(0, 99) < 40);
        ri = ($urandom_range(0, 99) < 65);
      end
      step(wi, ri, DW'($urandom));
      if (i == 300) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
